// File: rtl/tau_est_pkg.sv
// tau_est_pkg: definitions shared by the decay time-constant estimator.
//   state_t            measurement state machine encoding
//   E_INV_Q10_DEFAULT  1/e in Q0.10 (377/1024 ~= 0.368)
//   q10_scale()        unsigned value times a Q0.10 factor, truncated
package tau_est_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int E_INV_Q10_DEFAULT = 377;

  // Multiplies a 16-bit magnitude by a Q0.10 factor and drops the 10
  // fraction bits (truncation, no rounding). For a 12-bit sample and a
  // factor below 1024, the product fits in 22 bits and the result is
  // never larger than the input.
  function automatic logic [15:0] q10_scale(input logic [15:0] v,
                                            input logic [15:0] k);
    logic [31:0] p;
    p = {16'd0, v} * {16'd0, k};
    return p[25:10];
  endfunction

endpackage

// File: rtl/thr_cross_detect.sv
// thr_cross_detect: threshold-crossing confirmation for the tau estimator.
// Counts consecutive accepted samples at or below thr. It remembers the
// index of the first sample of the current run. A sample above thr breaks
// the run, so the candidate is taken again at the start of the next run.
//   clk, reset  clock, synchronous active-high reset
//   clear       drop the run and the candidate (outside a measurement)
//   step        a sample is accepted this cycle
//   sample      sample under test
//   thr         crossing threshold (a sample equal to thr counts as crossed)
//   idx         index of the sample being accepted
//   hit         this step completes a run of CONFIRM samples
//   cand        index of the first sample of the run that includes this step
module thr_cross_detect #(
  parameter int SAMPLE_W = 12,
  parameter int CNT_W    = 16,
  parameter int CONFIRM  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                step,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] thr,
  input  logic [CNT_W-1:0]    idx,
  output logic                hit,
  output logic [CNT_W-1:0]    cand
);

  logic [2:0]       run_q;
  logic [CNT_W-1:0] cand_q;
  logic             below;

  assign below = (sample <= thr);

  // An empty run means this sample would open a new run, so it supplies
  // the candidate itself.
  assign cand = (run_q == 3'd0) ? idx : cand_q;

  assign hit = step && below && (({1'b0, run_q} + 4'd1) == 4'(CONFIRM));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      run_q  <= 3'd0;
      cand_q <= '0;
    end else if (step) begin
      if (below) begin
        run_q  <= run_q + 3'd1;
        cand_q <= cand;
      end else begin
        run_q  <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/decay_tau_estimator.sv
// decay_tau_estimator: recovers the time constant of a decaying waveform.
// On start, the first valid sample becomes V0 at index 0, and
// thr = V0 * 1/e is latched. The block then counts valid samples until
// CONFIRM consecutive samples are at or below thr. The index of the first
// sample of that run is reported in tau_cycles.
//   clk, reset    clock, synchronous active-high reset
//   start         one-cycle request; also restarts a running measurement
//   sample_valid  sample is valid this cycle
//   sample        waveform sample (unsigned)
//   busy          measurement in progress (ARM or MEASURE)
//   done          one-cycle pulse when a result is final
//   tau_cycles    result index, held until the next done
//   timeout       index saturated without a crossing (held with tau_cycles)
//   err_small     V0 below MIN_V0 (held with tau_cycles)
module decay_tau_estimator
  import tau_est_pkg::*;
#(
  parameter int SAMPLE_W  = 12,
  parameter int CNT_W     = 16,
  parameter int E_INV_Q10 = E_INV_Q10_DEFAULT,
  parameter int CONFIRM   = 2,
  parameter int MIN_V0    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    tau_cycles,
  output logic                timeout,
  output logic                err_small
);

  localparam logic [CNT_W-1:0] IDX_MAX = '1;

  state_t              state, state_next;
  logic [SAMPLE_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]    idx_q;
  logic                capture_v0, step, clear, hit;
  logic [CNT_W-1:0]    cand;
  logic                load_res, res_timeout, res_err;
  logic [CNT_W-1:0]    res_tau;

  // Threshold of the sample currently on the input. It is only latched
  // when that sample is taken as V0.
  assign thr_d = SAMPLE_W'(q10_scale(16'(sample), 16'(E_INV_Q10)));

  thr_cross_detect #(
    .SAMPLE_W (SAMPLE_W),
    .CNT_W    (CNT_W),
    .CONFIRM  (CONFIRM)
  ) u_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .step   (step),
    .sample (sample),
    .thr    (thr_q),
    .idx    (idx_q),
    .hit    (hit),
    .cand   (cand)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture_v0  = 1'b0;
    step        = 1'b0;
    clear       = 1'b1;
    load_res    = 1'b0;
    res_tau     = '0;
    res_timeout = 1'b0;
    res_err     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ARM;
      end
      ARM: begin
        // A start here only re-arms; the sample seen with it is not V0.
        if (start) begin
          state_next = ARM;
        end else if (sample_valid) begin
          capture_v0 = 1'b1;
          if (sample < SAMPLE_W'(MIN_V0)) begin
            state_next = FINISH;
            load_res   = 1'b1;
            res_err    = 1'b1;
          end else begin
            state_next = MEASURE;
          end
        end
      end
      MEASURE: begin
        clear = 1'b0;
        if (start) begin
          // Abort: no result is published for the discarded run.
          state_next = ARM;
          clear      = 1'b1;
        end else if (sample_valid) begin
          step = 1'b1;
          if (hit) begin
            state_next = FINISH;
            load_res   = 1'b1;
            res_tau    = cand;
          end else if (idx_q == IDX_MAX) begin
            state_next  = FINISH;
            load_res    = 1'b1;
            res_timeout = 1'b1;
            res_tau     = IDX_MAX;
          end
        end
      end
      FINISH: begin
        state_next = start ? ARM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results load on the edge into FINISH, so they are already valid
  // during the done cycle and stay stable until the next done.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q      <= '0;
      idx_q      <= '0;
      tau_cycles <= '0;
      timeout    <= 1'b0;
      err_small  <= 1'b0;
    end else begin
      if (capture_v0) begin
        thr_q <= thr_d;
        idx_q <= CNT_W'(1);
      end else if (step) begin
        idx_q <= idx_q + CNT_W'(1);
      end else if (state_next == ARM) begin
        idx_q <= '0;
      end
      if (load_res) begin
        tau_cycles <= res_tau;
        timeout    <= res_timeout;
        err_small  <= res_err;
      end
    end
  end

  assign busy = (state == ARM) || (state == MEASURE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_decay_tau_estimator.sv
// tb_decay_tau_estimator: directed bench for decay_tau_estimator.
// Each expected result {timeout, err_small, tau_cycles} is queued when its
// stimulus is issued. A monitor compares it with the outputs on every done.
module tb_decay_tau_estimator;

  localparam int SAMPLE_W = 12;
  localparam int CNT_W    = 16;
  localparam int CONFIRM  = 2;
  localparam int RES_W    = CNT_W + 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    tau_cycles;
  logic                timeout;
  logic                err_small;

  int checks = 0;
  int errors = 0;
  logic [RES_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decay_tau_estimator dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .done         (done),
    .tau_cycles   (tau_cycles),
    .timeout      (timeout),
    .err_small    (err_small)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] pack(input logic t, input logic e, input int tau);
    logic [31:0] tv;
    tv = tau;
    return {t, e, tv[CNT_W-1:0]};
  endfunction

  // Reference for the closed-loop waveform: v[k] = v[k-1] - v[k-1]/16.
  function automatic int model_tau(input int v0, input int n);
    int thr, v, run, cand;
    thr  = (v0 * 377) >> 10;
    v    = v0;
    run  = 0;
    cand = 0;
    for (int i = 1; i < n; i++) begin
      v = v - (v >> 4);
      if (v <= thr) begin
        if (run == 0) cand = i;
        run++;
        if (run == CONFIRM) return cand;
      end else begin
        run = 0;
      end
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic v, input int value);
    logic [31:0] vv;
    vv = value;
    @(negedge clk);
    start        = s;
    sample_valid = v;
    sample       = vv[SAMPLE_W-1:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got tau=%0d timeout=%0d err_small=%0d, expected no done",
                 tau_cycles, timeout, err_small);
      end else begin
        logic [RES_W-1:0] e;
        e = exp_q.pop_front();
        check("result", 32'({timeout, err_small, tau_cycles}), 32'(e));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_cl;
    reset        = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tau", 32'(tau_cycles), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_err_small", 32'(err_small), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Linear ramp: V0=422 -> thr=155; 422-i <= 155 from i=267.
    exp_q.push_back(pack(1'b0, 1'b0, 267));
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i <= 268; i++) begin
      drive(1'b0, 1'b1, 422 - i);
      if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
      if (i == 268) check("done_not_early", 32'(done), 32'd0);
    end
    drive(1'b0, 1'b0, 0);
    check("ramp_done_timing", 32'(done), 32'd1);
    idle(2);
    check("ramp_result_hold", 32'(tau_cycles), 32'd267);

    // Glitch: the run at index 2 is broken by 200; the new run starts at 4.
    exp_q.push_back(pack(1'b0, 1'b0, 4));
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 422);
    drive(1'b0, 1'b1, 300);
    drive(1'b0, 1'b1, 150);
    drive(1'b0, 1'b1, 200);
    drive(1'b0, 1'b1, 154);
    drive(1'b0, 1'b1, 153);
    idle(3);

    // Small V0, and the MIN_V0 boundary on both sides.
    exp_q.push_back(pack(1'b0, 1'b1, 0));
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 5);
    idle(3);
    exp_q.push_back(pack(1'b0, 1'b1, 0));
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 7);
    idle(3);
    // V0=8 -> thr=2; sample 2 equals thr and counts as crossed.
    exp_q.push_back(pack(1'b0, 1'b0, 2));
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b1, 2);
    idle(3);
    check("flags_cleared", 32'({timeout, err_small}), 32'd0);

    // Restart at index 100; the new V0=100 gives thr=36, crossing at 64.
    exp_q.push_back(pack(1'b0, 1'b0, 64));
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 422 - i);
    drive(1'b1, 1'b1, 322);
    for (int i = 0; i <= 65; i++) drive(1'b0, 1'b1, 100 - i);
    idle(3);
    check("restart_result", 32'(tau_cycles), 32'd64);

    // Reset mid-MEASURE: everything returns to its reset value.
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 422 - i);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_tau", 32'(tau_cycles), 32'd0);
    check("midrst_flags", 32'({timeout, err_small}), 32'd0);
    // start together with reset: reset wins.
    start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    idle(2);

    // Closed loop, fully valid and then with 50% valid (garbage 0 on invalid cycles).
    exp_cl = model_tau(4000, 60);
    exp_q.push_back(pack(1'b0, 1'b0, exp_cl));
    begin
      int v;
      v = 4000;
      drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 60; i++) begin
        drive(1'b0, 1'b1, v);
        v = v - (v >> 4);
      end
      idle(3);
      exp_q.push_back(pack(1'b0, 1'b0, exp_cl));
      v = 4000;
      drive(1'b1, 1'b0, 0);
      for (int i = 0; i < 60; i++) begin
        drive(1'b0, 1'b1, v);
        drive(1'b0, 1'b0, 0);
        v = v - (v >> 4);
      end
      idle(3);
    end

    // Timeout: V0=422, then 65535 samples of 400 never reach thr=155.
    exp_q.push_back(pack(1'b1, 1'b0, 65535));
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 422);
    for (int i = 1; i <= 65535; i++) drive(1'b0, 1'b1, 400);
    idle(3);
    check("timeout_hold", 32'({timeout, err_small, tau_cycles}), 32'(pack(1'b1, 1'b0, 65535)));

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
